// File: rtl/orb_desc_pingpong_buffer.sv
// Two-bank ping-pong store for ORB descriptor/location entries.
// The writer fills one bank per frame while the consumer claims and reads a finished bank.
module orb_desc_pingpong_buffer #(
    parameter int DESC_W = 256,
    parameter int LOC_W  = 32,
    parameter int DEPTH  = 2048
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_start,
    input  logic                    i_end,
    input  logic                    i_valid,
    input  logic [DESC_W+LOC_W-1:0] i_value,
    output logic                    o_ready,
    output logic                    o_bank,
    output logic [15:0]             o_length,
    output logic                    o_overflow,
    input  logic                    i_ready_ack,
    input  logic                    i_release,
    input  logic                    i_rd_en,
    input  logic [15:0]             i_rd_addr,
    output logic [DESC_W-1:0]       o_rd_desc,
    output logic [LOC_W-1:0]        o_rd_loc,
    output logic                    o_rd_valid,
    output logic [7:0]              o_drop_cnt
);
    localparam int          ENTRY_W = DESC_W + LOC_W;
    localparam int          ADDR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [15:0] DEPTH_L = 16'(DEPTH);

    typedef enum logic [1:0] {B_FREE, B_FILL, B_FULL, B_READ} bank_t;
    typedef enum logic [1:0] {W_IDLE, W_WRITE, W_DROP} wr_t;

    bank_t       bank_q [2];
    bank_t       bank_d [2];
    logic [15:0] len_q  [2];
    logic [15:0] len_d  [2];
    logic        ovf_q  [2];
    logic        ovf_d  [2];
    wr_t         wr_q, wr_d;
    logic        fill_q, fill_d;
    logic        oldest_q, oldest_d;
    logic [7:0]  drop_q, drop_d;
    logic        ready_q, ready_d;
    logic        pres_bank_q, pres_bank_d;
    logic [15:0] pres_len_q, pres_len_d;
    logic        pres_ovf_q, pres_ovf_d;
    logic        pbank;
    logic        wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic        rd_sel, rd_hit;
    logic        rd_valid_q, rd_zero_q, rd_bank_q;
    logic [ENTRY_W-1:0] rd_word;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            bank_d[i] = bank_q[i];
            len_d[i]  = len_q[i];
            ovf_d[i]  = ovf_q[i];
        end
        wr_d     = wr_q;
        fill_d   = fill_q;
        oldest_d = oldest_q;
        drop_d   = drop_q;
        wr_en    = 1'b0;
        wr_addr  = len_q[fill_q][ADDR_W-1:0];

        for (int i = 0; i < 2; i++) begin
            if (i_release && bank_q[i] == B_READ) bank_d[i] = B_FREE;
        end
        if (ready_q && i_ready_ack) bank_d[pres_bank_q] = B_READ;

        if (i_start) begin
            // An aborted frame frees its bank before the free-bank search.
            if (wr_q == W_WRITE) bank_d[fill_q] = B_FREE;
            if (bank_d[0] == B_FREE || bank_d[1] == B_FREE) begin
                fill_d         = (bank_d[0] != B_FREE);
                bank_d[fill_d] = B_FILL;
                len_d[fill_d]  = '0;
                ovf_d[fill_d]  = 1'b0;
                wr_d           = W_WRITE;
            end else begin
                wr_d = W_DROP;
                if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
            end
        end else if (wr_q == W_WRITE) begin
            if (i_valid) begin
                if (len_q[fill_q] < DEPTH_L) begin
                    wr_en         = 1'b1;
                    len_d[fill_q] = len_q[fill_q] + 16'd1;
                end else begin
                    ovf_d[fill_q] = 1'b1;
                end
            end
            if (i_end) begin
                bank_d[fill_q] = B_FULL;
                wr_d           = W_IDLE;
                if (bank_d[~fill_q] != B_FULL) oldest_d = fill_q;
            end
        end else if (wr_q == W_DROP && i_end) begin
            wr_d = W_IDLE;
        end

        ready_d = (bank_d[0] == B_FULL || bank_d[1] == B_FULL) &&
                  bank_d[0] != B_READ && bank_d[1] != B_READ;
        pbank   = (bank_d[0] == B_FULL && bank_d[1] == B_FULL) ? oldest_d
                                                                : (bank_d[1] == B_FULL);
        pres_bank_d = ready_d ? pbank : 1'b0;
        pres_len_d  = ready_d ? len_d[pbank] : 16'd0;
        pres_ovf_d  = ready_d ? ovf_d[pbank] : 1'b0;
    end

    always_comb begin
        rd_sel = (bank_q[1] == B_READ);
        rd_hit = (bank_q[0] == B_READ || bank_q[1] == B_READ) && (i_rd_addr < len_q[rd_sel]);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < 2; i++) begin
                bank_q[i] <= B_FREE;
                len_q[i]  <= '0;
                ovf_q[i]  <= 1'b0;
            end
            wr_q        <= W_IDLE;
            fill_q      <= 1'b0;
            oldest_q    <= 1'b0;
            drop_q      <= '0;
            ready_q     <= 1'b0;
            pres_bank_q <= 1'b0;
            pres_len_q  <= '0;
            pres_ovf_q  <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_zero_q   <= 1'b1;
            rd_bank_q   <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                bank_q[i] <= bank_d[i];
                len_q[i]  <= len_d[i];
                ovf_q[i]  <= ovf_d[i];
            end
            wr_q        <= wr_d;
            fill_q      <= fill_d;
            oldest_q    <= oldest_d;
            drop_q      <= drop_d;
            ready_q     <= ready_d;
            pres_bank_q <= pres_bank_d;
            pres_len_q  <= pres_len_d;
            pres_ovf_q  <= pres_ovf_d;
            rd_valid_q  <= i_rd_en;
            rd_zero_q   <= ~(i_rd_en && rd_hit);
            rd_bank_q   <= rd_sel;
        end
    end

    // RAM read registers carry no reset so the banks map onto block RAM.
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
        logic [ENTRY_W-1:0] mem [DEPTH];
        logic [ENTRY_W-1:0] rd_raw_q;
        always_ff @(posedge i_clk) begin
            if (wr_en && fill_q == 1'(gi)) mem[wr_addr] <= i_value;
            if (i_rd_en) rd_raw_q <= mem[i_rd_addr[ADDR_W-1:0]];
        end
    end

    assign rd_word    = rd_bank_q ? g_bank[1].rd_raw_q : g_bank[0].rd_raw_q;
    assign o_rd_desc  = rd_zero_q ? '0 : rd_word[ENTRY_W-1:LOC_W];
    assign o_rd_loc   = rd_zero_q ? '0 : rd_word[LOC_W-1:0];
    assign o_rd_valid = rd_valid_q;
    assign o_ready    = ready_q;
    assign o_bank     = pres_bank_q;
    assign o_length   = pres_len_q;
    assign o_overflow = pres_ovf_q;
    assign o_drop_cnt = drop_q;
endmodule

// File: tb/tb_orb_desc_pingpong_buffer.sv
// Directed bench: dut_a (DEPTH=16) covers framing, drop and reads; dut_b (DEPTH=4) covers overflow.
module tb_orb_desc_pingpong_buffer;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0, fend = 1'b0, valid = 1'b0;
    logic [15:0] value = '0;
    logic        ack = 1'b0, rel = 1'b0, rd_en = 1'b0;
    logic [15:0] rd_addr = '0;

    logic        a_ready, a_bank, a_ovf, a_rd_valid;
    logic [15:0] a_len;
    logic [7:0]  a_desc, a_loc, a_drop;
    logic        b_ready, b_bank, b_ovf, b_rd_valid;
    logic [15:0] b_len;
    logic [7:0]  b_desc, b_loc, b_drop;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    orb_desc_pingpong_buffer #(.DESC_W(8), .LOC_W(8), .DEPTH(16)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_end(fend), .i_valid(valid),
        .i_value(value), .o_ready(a_ready), .o_bank(a_bank), .o_length(a_len),
        .o_overflow(a_ovf), .i_ready_ack(ack), .i_release(rel), .i_rd_en(rd_en),
        .i_rd_addr(rd_addr), .o_rd_desc(a_desc), .o_rd_loc(a_loc),
        .o_rd_valid(a_rd_valid), .o_drop_cnt(a_drop)
    );

    orb_desc_pingpong_buffer #(.DESC_W(8), .LOC_W(8), .DEPTH(4)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_end(fend), .i_valid(valid),
        .i_value(value), .o_ready(b_ready), .o_bank(b_bank), .o_length(b_len),
        .o_overflow(b_ovf), .i_ready_ack(ack), .i_release(rel), .i_rd_en(rd_en),
        .i_rd_addr(rd_addr), .o_rd_desc(b_desc), .o_rd_loc(b_loc),
        .o_rd_valid(b_rd_valid), .o_drop_cnt(b_drop)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    // Drive one cycle of stimulus; outputs are sampled 1ns after the edge.
    task automatic step(input logic s, input logic e, input logic v, input logic [15:0] val,
                        input logic a, input logic r, input logic re, input logic [15:0] ad);
        start = s; fend = e; valid = v; value = val;
        ack = a; rel = r; rd_en = re; rd_addr = ad;
        @(posedge clk); #1;
        start = 0; fend = 0; valid = 0; value = '0;
        ack = 0; rel = 0; rd_en = 0; rd_addr = '0;
    endtask

    task automatic do_start();            step(1, 0, 0, 16'h0, 0, 0, 0, 16'h0); endtask
    task automatic do_end();              step(0, 1, 0, 16'h0, 0, 0, 0, 16'h0); endtask
    task automatic do_valid(input logic [15:0] v); step(0, 0, 1, v, 0, 0, 0, 16'h0); endtask
    task automatic do_ack();              step(0, 0, 0, 16'h0, 1, 0, 0, 16'h0); endtask
    task automatic do_rel();              step(0, 0, 0, 16'h0, 0, 1, 0, 16'h0); endtask
    task automatic do_read(input logic [15:0] ad); step(0, 0, 0, 16'h0, 0, 0, 1, ad); endtask

    task automatic do_reset();
        rst = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 0;
    endtask

    initial begin
        // Reset state
        do_reset();
        check("rst_ready", a_ready, 0);
        check("rst_len", a_len, 0);
        check("rst_rd_valid", a_rd_valid, 0);
        check("rst_drop", a_drop, 0);

        // Single 5-entry frame into bank 0, read back last entry
        do_start();
        for (int i = 1; i <= 5; i++) do_valid({8'(8'h10 + i), 8'(i)});
        do_end();
        check("f1_ready", a_ready, 1);
        check("f1_bank", a_bank, 0);
        check("f1_len", a_len, 5);
        check("f1_ovf", a_ovf, 0);
        do_ack();
        check("f1_ready_after_ack", a_ready, 0);
        do_read(16'd4);
        check("f1_rd_valid", a_rd_valid, 1);
        check("f1_rd_loc", a_loc, 8'h05);
        check("f1_rd_desc", a_desc, 8'h15);
        do_read(16'd5);
        check("f1_oob_valid", a_rd_valid, 1);
        check("f1_oob_loc", a_loc, 0);
        do_rel();
        check("f1_rd_valid_idle", a_rd_valid, 0);
        check("f1_ready_after_rel", a_ready, 0);

        // Two frames buffered, third dropped, then bank 1 presented after release
        do_reset();
        do_start();
        for (int i = 0; i < 3; i++) do_valid({8'hA0, 8'(8'h20 + i)});
        do_end();
        do_start();
        for (int i = 0; i < 7; i++) do_valid({8'hB0, 8'(8'h40 + i)});
        do_end();
        check("two_ready", a_ready, 1);
        check("two_bank", a_bank, 0);
        check("two_len", a_len, 3);
        do_start();
        do_valid(16'hFFFF);
        do_end();
        check("drop_cnt", a_drop, 1);
        check("drop_len_kept", a_len, 3);
        do_ack();
        do_read(16'd2);
        check("two_rd_loc", a_loc, 8'h22);
        check("two_rd_desc", a_desc, 8'hA0);
        do_rel();
        check("two_next_ready", a_ready, 1);
        check("two_next_bank", a_bank, 1);
        check("two_next_len", a_len, 7);

        // Overflow on DEPTH=4 instance
        do_reset();
        do_start();
        for (int i = 0; i < 6; i++) do_valid({8'hC0, 8'(8'h30 + i)});
        do_end();
        check("ovf_ready", b_ready, 1);
        check("ovf_len", b_len, 4);
        check("ovf_flag", b_ovf, 1);
        do_ack();
        for (int i = 0; i < 4; i++) begin
            do_read(16'(i));
            check($sformatf("ovf_rd%0d_loc", i), b_loc, 32'(8'h30 + i));
        end
        do_read(16'd4);
        check("ovf_oob_loc", b_loc, 0);

        // Aborted frame: restart reuses bank 0
        do_reset();
        do_start();
        for (int i = 0; i < 3; i++) do_valid({8'hD0, 8'(8'h50 + i)});
        do_start();
        for (int i = 0; i < 2; i++) do_valid({8'hE0, 8'(8'h60 + i)});
        do_end();
        check("abort_ready", a_ready, 1);
        check("abort_bank", a_bank, 0);
        check("abort_len", a_len, 2);
        check("abort_drop", a_drop, 0);
        do_ack();
        do_read(16'd0);
        check("abort_rd0_loc", a_loc, 8'h60);
        do_read(16'd2);
        check("abort_rd2_valid", a_rd_valid, 1);
        check("abort_rd2_loc", a_loc, 0);
        check("abort_rd2_desc", a_desc, 0);

        // Reset while bank 0 READ and bank 1 FILL, with a concurrent write/read
        do_reset();
        do_start();
        do_valid(16'hF170);
        do_valid(16'hF171);
        do_end();
        do_ack();
        do_start();
        step(0, 0, 1, 16'h0F80, 0, 0, 1, 16'd0);
        check("conc_rd_valid", a_rd_valid, 1);
        check("conc_rd_loc", a_loc, 8'h70);
        rst = 1;
        #1;
        check("async_rd_valid", a_rd_valid, 0);
        check("async_rd_loc", a_loc, 0);
        check("async_rd_desc", a_desc, 0);
        check("async_ready", a_ready, 0);
        @(posedge clk); #1;
        rst = 0;
        do_start();
        do_valid(16'h1290);
        do_end();
        check("post_rst_ready", a_ready, 1);
        check("post_rst_bank", a_bank, 0);
        check("post_rst_len", a_len, 1);
        do_ack();
        do_read(16'd0);
        check("post_rst_rd_loc", a_loc, 8'h90);
        check("post_rst_rd_desc", a_desc, 8'h12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
